// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the two-port RAM arbiter.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN_A,
    OWN_B
  } arb_state_t;

  typedef enum logic {
    REQ_A,
    REQ_B
  } requester_t;

  // On a tie the port not granted last time wins.
  function automatic requester_t rr_pick(
    input logic       a_req,
    input logic       b_req,
    input requester_t last_gnt
  );
    if (a_req && b_req) begin
      if (last_gnt == REQ_A) return REQ_B;
      return REQ_A;
    end
    if (b_req) return REQ_B;
    return REQ_A;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_grant2.sv
// Combinational two-way round-robin pick used when no port owns the RAM.
module rr_grant2
  import ram_arbiter_pkg::*;
(
  input  logic       a_req,
  input  logic       b_req,
  input  requester_t last_gnt,
  output logic       a_gnt,
  output logic       b_gnt
);

  requester_t win;

  assign win   = rr_pick(a_req, b_req, last_gnt);
  assign a_gnt = a_req & (win == REQ_A);
  assign b_gnt = b_req & (win == REQ_B);

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between fetch (A) and load/store (B)
// with round-robin arbitration and a bounded exclusive lock.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int W        = 32,
  parameter int L        = 128,
  parameter int MAX_LOCK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_req,
  input  logic                 a_lock,
  input  logic                 a_wr_ena,
  input  logic [$clog2(L)-1:0] a_addr,
  input  logic [W-1:0]         a_wr_data,
  input  logic                 b_req,
  input  logic                 b_lock,
  input  logic                 b_wr_ena,
  input  logic [$clog2(L)-1:0] b_addr,
  input  logic [W-1:0]         b_wr_data,
  output logic                 a_gnt,
  output logic                 b_gnt,
  output logic                 a_rd_valid,
  output logic                 b_rd_valid,
  output logic [W-1:0]         a_rd_data,
  output logic [W-1:0]         b_rd_data,
  output logic [$clog2(L)-1:0] ram_addr,
  output logic                 ram_wr_ena,
  output logic [W-1:0]         ram_wr_data,
  input  logic [W-1:0]         ram_rd_data
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  arb_state_t     state;
  requester_t     last_gnt;
  logic [CW-1:0]  lock_cnt;
  logic           rr_a;
  logic           rr_b;
  logic           at_max;
  logic [CW-1:0]  cnt_inc;

  rr_grant2 u_rr (
    .a_req    (a_req),
    .b_req    (b_req),
    .last_gnt (last_gnt),
    .a_gnt    (rr_a),
    .b_gnt    (rr_b)
  );

  assign at_max  = (lock_cnt == CW'(MAX_LOCK));
  assign cnt_inc = at_max ? lock_cnt : lock_cnt + CW'(1);

  // Owner keeps the RAM until it drops req or the other side hits the bound.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      unique case (state)
        OWN_A: begin
          if (a_req) begin
            if (b_req && at_max) b_gnt = 1'b1;
            else                 a_gnt = 1'b1;
          end else begin
            a_gnt = rr_a;
            b_gnt = rr_b;
          end
        end
        OWN_B: begin
          if (b_req) begin
            if (a_req && at_max) a_gnt = 1'b1;
            else                 b_gnt = 1'b1;
          end else begin
            a_gnt = rr_a;
            b_gnt = rr_b;
          end
        end
        default: begin
          a_gnt = rr_a;
          b_gnt = rr_b;
        end
      endcase
    end
  end

  assign ram_addr    = a_gnt ? a_addr :
                       b_gnt ? b_addr : '0;
  assign ram_wr_data = a_gnt ? a_wr_data :
                       b_gnt ? b_wr_data : '0;
  assign ram_wr_ena  = (a_gnt & a_wr_ena) |
                       (b_gnt & b_wr_ena);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_gnt   <= REQ_B;
      lock_cnt   <= '0;
      a_rd_valid <= 1'b0;
      b_rd_valid <= 1'b0;
      a_rd_data  <= '0;
      b_rd_data  <= '0;
    end else begin
      a_rd_valid <= a_gnt & ~a_wr_ena;
      b_rd_valid <= b_gnt & ~b_wr_ena;
      if (a_gnt && !a_wr_ena) a_rd_data <= ram_rd_data;
      if (b_gnt && !b_wr_ena) b_rd_data <= ram_rd_data;
      if (a_gnt) begin
        last_gnt <= REQ_A;
        if (a_lock) begin
          state    <= OWN_A;
          lock_cnt <= (state == OWN_A) ? cnt_inc : CW'(1);
        end else begin
          state    <= IDLE;
          lock_cnt <= '0;
        end
      end else if (b_gnt) begin
        last_gnt <= REQ_B;
        if (b_lock) begin
          state    <= OWN_B;
          lock_cnt <= (state == OWN_B) ? cnt_inc : CW'(1);
        end else begin
          state    <= IDLE;
          lock_cnt <= '0;
        end
      end else begin
        state    <= IDLE;
        lock_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed scoreboard bench for ram_arbiter with a behavioural RAM.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, a_lock = 1'b0, a_wr_ena = 1'b0;
  logic        b_req = 1'b0, b_lock = 1'b0, b_wr_ena = 1'b0;
  logic [6:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_wr_data = '0, b_wr_data = '0;
  logic        a_gnt, b_gnt, a_rd_valid, b_rd_valid;
  logic [31:0] a_rd_data, b_rd_data;
  logic [6:0]  ram_addr;
  logic        ram_wr_ena;
  logic [31:0] ram_wr_data, ram_rd_data;

  int tests = 0;
  int fails = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  logic [31:0] mem[128];
  bit          written[128];

  always #5 clk = ~clk;

  ram_arbiter #(.W(32), .L(128), .MAX_LOCK(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_req       (a_req),
    .a_lock      (a_lock),
    .a_wr_ena    (a_wr_ena),
    .a_addr      (a_addr),
    .a_wr_data   (a_wr_data),
    .b_req       (b_req),
    .b_lock      (b_lock),
    .b_wr_ena    (b_wr_ena),
    .b_addr      (b_addr),
    .b_wr_data   (b_wr_data),
    .a_gnt       (a_gnt),
    .b_gnt       (b_gnt),
    .a_rd_valid  (a_rd_valid),
    .b_rd_valid  (b_rd_valid),
    .a_rd_data   (a_rd_data),
    .b_rd_data   (b_rd_data),
    .ram_addr    (ram_addr),
    .ram_wr_ena  (ram_wr_ena),
    .ram_wr_data (ram_wr_data),
    .ram_rd_data (ram_rd_data)
  );

  function automatic logic [31:0] init_val(input logic [6:0] a);
    if (a == 7'd5) return 32'h0000_0013;
    return 32'h100 + {25'd0, a};
  endfunction

  assign ram_rd_data = written[ram_addr] ? mem[ram_addr]
                                         : init_val(ram_addr);

  always @(posedge clk) begin
    if (ram_wr_ena) begin
      mem[ram_addr]     <= ram_wr_data;
      written[ram_addr] <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_rd_valid) begin
      if (qa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_rd_valid: unexpected pulse data %h", a_rd_data);
      end else begin
        chk("a_rd_data", a_rd_data, qa.pop_front());
      end
    end
    if (b_rd_valid) begin
      if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_rd_valid: unexpected pulse data %h", b_rd_data);
      end else begin
        chk("b_rd_data", b_rd_data, qb.pop_front());
      end
    end
  end

  task automatic cyc(
    input bit r,
    input bit ar, input bit al, input bit aw,
    input logic [6:0] aa, input logic [31:0] ad,
    input bit br, input bit bl, input bit bw,
    input logic [6:0] ba, input logic [31:0] bd,
    input bit ega, input bit egb,
    input logic [31:0] erd, input string nm
  );
    logic       ewe;
    logic [6:0] ead;
    @(posedge clk);
    #1;
    rst = r;
    a_req = ar; a_lock = al; a_wr_ena = aw;
    a_addr = aa; a_wr_data = ad;
    b_req = br; b_lock = bl; b_wr_ena = bw;
    b_addr = ba; b_wr_data = bd;
    #1;
    ewe = ega ? aw : (egb ? bw : 1'b0);
    ead = ega ? aa : (egb ? ba : 7'd0);
    chk({nm, ".a_gnt"}, {31'd0, a_gnt}, {31'd0, ega});
    chk({nm, ".b_gnt"}, {31'd0, b_gnt}, {31'd0, egb});
    chk({nm, ".wr_ena"}, {31'd0, ram_wr_ena}, {31'd0, ewe});
    chk({nm, ".addr"}, {25'd0, ram_addr}, {25'd0, ead});
    if (ega && !aw) qa.push_back(erd);
    if (egb && !bw) qb.push_back(erd);
  endtask

  task automatic idle(input string nm);
    cyc(0, 0,0,0,7'd0,32'd0, 0,0,0,7'd0,32'd0, 0,0,32'd0, nm);
  endtask

  initial begin
    logic [6:0] aa;
    logic [6:0] ba;
    cyc(1, 0,0,0,7'd0,32'd0, 0,0,0,7'd0,32'd0, 0,0,32'd0, "rst0");
    cyc(1, 0,0,0,7'd0,32'd0, 0,0,0,7'd0,32'd0, 0,0,32'd0, "rst1");
    chk("rst.a_rd_data", a_rd_data, 32'd0);
    chk("rst.b_rd_data", b_rd_data, 32'd0);
    chk("rst.a_rd_valid", {31'd0, a_rd_valid}, 32'd0);

    cyc(0, 1,0,0,7'd5,32'd0, 0,0,0,7'd0,32'd0, 1,0,32'h13, "t1");
    idle("t1i");
    chk("t1.a_rd_valid", {31'd0, a_rd_valid}, 32'd1);
    chk("t1.b_rd_valid", {31'd0, b_rd_valid}, 32'd0);
    chk("t1.b_rd_data", b_rd_data, 32'd0);

    cyc(0, 0,0,0,7'd0,32'd0, 1,0,1,7'd10,32'hDEAD_BEEF, 0,1,32'd0, "wr");
    cyc(0, 0,0,0,7'd0,32'd0, 1,0,0,7'd10,32'd0, 0,1,32'hDEAD_BEEF, "rd");
    idle("wri");

    for (int i = 0; i < 6; i++) begin
      aa = 7'(20 + (i + 1) / 2);
      ba = 7'(30 + i / 2);
      cyc(0, 1,0,0,aa,32'd0, 1,0,0,ba,32'd0, (i % 2) == 0, (i % 2) == 1,
          (i % 2) == 0 ? 32'h100 + {25'd0, aa} : 32'h100 + {25'd0, ba},
          "tie");
    end
    idle("tiei");

    cyc(0, 1,0,0,7'd40,32'd0, 0,0,0,7'd0,32'd0, 1,0,32'h128, "pre");
    for (int i = 0; i < 8; i++) begin
      aa = (i <= 4) ? 7'd60 : 7'd61;
      ba = 7'(50 + ((i <= 4) ? i : i - 1));
      cyc(0, 1,0,0,aa,32'd0, 1,1,0,ba,32'd0, i == 4, i != 4,
          (i == 4) ? 32'h13C : 32'h100 + {25'd0, ba}, "lockb");
    end

    for (int i = 0; i < 10; i++) begin
      aa = 7'(70 + i);
      cyc(0, 1,1,0,aa,32'd0, 0,0,0,7'd0,32'd0, 1,0,
          32'h100 + {25'd0, aa}, "locka");
    end
    idle("lockai");
    chk("lock_cnt.sat", {29'd0, dut.lock_cnt}, 32'd4);

    cyc(0, 0,0,0,7'd0,32'd0, 1,1,0,7'd80,32'd0, 0,1,32'h150, "own");
    cyc(1, 1,0,0,7'd90,32'd0, 1,1,0,7'd81,32'd0, 0,0,32'd0, "rstm");
    cyc(0, 1,0,0,7'd90,32'd0, 1,0,0,7'd81,32'd0, 1,0,32'h15A, "ptie");
    cyc(0, 0,0,0,7'd0,32'd0, 1,0,0,7'd81,32'd0, 0,1,32'h151, "pb");
    idle("end0");
    idle("end1");
    idle("end2");
    chk("qa.left", qa.size(), 32'd0);
    chk("qb.left", qb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares one single-port distributed RAM between an instruction-fetch requester (port A) and a load/store requester (port B) in the RISC-V CPU. It grants at most one requester per cycle using round-robin between the two, and drives the RAM address, write-enable and write-data lines. It returns registered read data with a one-cycle valid pulse. It also supports a bounded lock so one requester can hold the RAM for back-to-back accesses, such as read-modify-write sequences.

## Interface
- `W`, 32, RAM word width in bits
- `L`, 128, RAM depth in words; address width is `$clog2(L)`
- `MAX_LOCK`, 4, maximum consecutive locked grants to one requester while the other is requesting
- `clk`  in  1  system clock; all state updates on its rising edge
- `rst`  in  1  reset, synchronous and active-high
- `a_req` / `b_req`  in  1  access request; held until granted
- `a_lock` / `b_lock`  in  1  request exclusive ownership after this grant
- `a_wr_ena` / `b_wr_ena`  in  1  1 = write, 0 = read
- `a_addr` / `b_addr`  in  `$clog2(L)`  word address
- `a_wr_data` / `b_wr_data`  in  W  write data
- `a_gnt` / `b_gnt`  out  1  combinational grant; the access is performed on the coming edge
- `a_rd_valid` / `b_rd_valid`  out  1  registered one-cycle pulse: read data is valid
- `a_rd_data` / `b_rd_data`  out  W  registered read data; holds its value until the next read for that port
- `ram_addr`  out  `$clog2(L)`  RAM address
- `ram_wr_ena`  out  1  RAM write enable
- `ram_wr_data`  out  W  RAM write data
- `ram_rd_data`  in  W  combinational RAM read data

## Operation
- State is `IDLE`, `OWN_A` or `OWN_B`. Additional registers:
  - `last_gnt`: the requester granted most recently.
  - `lock_cnt`: width `$clog2(MAX_LOCK+1)`, saturating.
- **IDLE arbitration:**
  - If exactly one requester asserts req, it is granted.
  - If both assert req, the requester that is not `last_gnt` is granted.
- **On any grant to requester x:**
  - `last_gnt` is set to x.
  - If `x_lock`=1 and x was not force-released this cycle, the next state is `OWN_x` and `lock_cnt` becomes 1, or increments if already in `OWN_x`.
  - Otherwise the next state is `IDLE` and `lock_cnt` becomes 0.
- **OWN_x:**
  - The other requester is never granted while x keeps `x_req`=1 and `lock_cnt` < `MAX_LOCK`.
  - If the other requester is requesting and `lock_cnt` == `MAX_LOCK`, x is force-released. The other requester is granted this cycle, and its own lock rules apply.
  - If the other requester is idle, x continues to be granted past `MAX_LOCK`; `lock_cnt` saturates.
  - If `x_req`=0, IDLE arbitration applies in the same cycle, so there is no dead cycle.
- **RAM drive:**
  - `ram_addr` and `ram_wr_data` come from the granted port, or are all-zero when no port is granted.
  - `ram_wr_ena` = `gnt` & `wr_ena` of the granted port.
- **Read return:** on the edge ending a granted read, `ram_rd_data` is captured into `x_rd_data` and `x_rd_valid` pulses for one cycle. A granted write produces no valid pulse.
- An ungranted requester must hold `req`, `addr`, `wr_ena` and `wr_data` stable. The arbiter keeps no queue.

## Timing
- Grant latency is 0 cycles: `gnt` is combinational from the current state and requests.
- Read data latency is 1 cycle after the grant cycle.
- A write takes effect at the grant-cycle edge. A read of the same address in the next cycle returns the new data.
- Sustained throughput is one access per cycle. With both ports requesting and no locks, grants alternate A, B, A, B…
- **Reset:** `rst` overrides everything in the cycle it is high.
  - Both `gnt` outputs and `ram_wr_ena` are forced to 0.
  - Next state is `IDLE`, `last_gnt`=B (so A wins the first tie) and `lock_cnt`=0.
  - `rd_valid`=0 and `rd_data`=0 on both ports.
- Reset asserted mid-lock drops ownership immediately. No pending read pulse is emitted.
- Simultaneous release by the owner and request by the other: the other requester is granted that same cycle.

## Structure
- `ram_arbiter_pkg` holds:
  - `arb_state_t` enum (`IDLE`, `OWN_A`, `OWN_B`);
  - `requester_t` enum (`REQ_A`, `REQ_B`);
  - a helper function returning the round-robin winner for two requests and `last_gnt`.
- There is one sub-module, `rr_grant2`: pure combinational two-way round-robin pick used by IDLE arbitration.
- The RAM itself is not instantiated inside this block. The top level connects the `ram_*` ports to it.

## Test plan
- **Reset, then single read:** after reset, A reads addr 5 with RAM preloaded to 0x0000_0013.
  - `a_gnt`=1 in cycle 0.
  - `a_rd_valid`=1 and `a_rd_data`=0x0000_0013 in cycle 1.
  - B outputs stay 0.
- **Tie alternation:** both ports request every cycle, unlocked, for 6 cycles. Grants are A,B,A,B,A,B; each port gets 3 valid pulses carrying the correct data.
- **Write-then-read:** B writes 0xDEAD_BEEF to addr 10, then B reads addr 10 the next cycle. `b_rd_data`=0xDEAD_BEEF one cycle after the read grant, with no valid pulse for the write.
- **Lock bound:** with `MAX_LOCK`=4, B holds lock and req for 8 cycles while A requests continuously.
  - B is granted 4 times, then A is granted.
  - With A unlocked, B is granted again the next cycle.
- **Lock with idle competitor:** A holds lock for 10 cycles and B is idle. A is granted all 10 cycles and `lock_cnt` saturates at 4.
- **Reset mid-lock:** `rst` is asserted during `OWN_B` with a read grant in flight.
  - Both gnt=0 and `ram_wr_ena`=0 in the `rst` cycle.
  - No `b_rd_valid` pulse follows.
  - The first tie after reset goes to A.
